// File: rtl/isa_seq_pkg.sv
// Shared types and constants for the ISA test sequencer: FSM states,
// the tohost pass encoding and the bit layout of the status LED vector.
package isa_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      HOLD,
      RUN,
      DONE
   } seq_state_t;

   localparam logic [31:0] TOHOST_PASS = 32'h1;

   localparam int LED_DONE     = 0;
   localparam int LED_PASS     = 1;
   localparam int LED_TIMEOUT  = 2;
   localparam int LED_LOAD_ERR = 3;
   localparam int LED_W        = 4;

   function automatic logic [LED_W-1:0] status_leds(input logic done,
                                                    input logic pass,
                                                    input logic timeout,
                                                    input logic load_err);
      logic [LED_W-1:0] leds;
      leds               = '0;
      leds[LED_DONE]     = done;
      leds[LED_PASS]     = pass;
      leds[LED_TIMEOUT]  = timeout;
      leds[LED_LOAD_ERR] = load_err;
      return leds;
   endfunction

endpackage

// File: rtl/isa_test_sequencer_if.sv
// Image stream from the loader (UART or bench) into the sequencer.
// Valid/ready handshake; a word transfers on a cycle where both are high.
interface isa_test_sequencer_if;
   logic        load_valid;
   logic        load_ready;
   logic [31:0] load_data;
   logic        load_last;

   modport master (output load_valid, output load_data, output load_last, input load_ready);
   modport slave  (input load_valid, input load_data, input load_last, output load_ready);
endinterface

// File: rtl/isa_seq_watchdog.sv
// RUN-state cycle counter and watchdog; TIMEOUT_CYCLES = 0 disables expiry.
module isa_seq_watchdog #(
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        clear,
   output logic [31:0] cycle_count,
   output logic        expired
);

   // NOTE: sequential state uses non-blocking assignment so every flop sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cycle_count <= '0;
      end else if (enable) begin
         cycle_count <= cycle_count + 32'd1;
      end
   end

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_no_watchdog
         assign expired = 1'b0;
      end else begin : g_watchdog
         localparam logic [31:0] LIMIT = 32'(TIMEOUT_CYCLES - 1);
         assign expired = (cycle_count == LIMIT);
      end
   endgenerate

endmodule

// File: rtl/isa_test_sequencer.sv
// Loads an RV32I test image, runs the CPU and latches pass/fail/timeout.
// Define ISA_SEQ_CSR_SYNC_EN to pass csr through a two-flop synchronizer.
module isa_test_sequencer
   import isa_seq_pkg::*;
#(
   parameter int ADDR_W         = 14,
   parameter int RESET_HOLD     = 30,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   isa_test_sequencer_if.slave   ld,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  cpu_rst,
   input  logic [31:0]           csr,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [30:0]           fail_id,
   output logic                  timeout,
   output logic                  load_err,
   output logic [31:0]           cycle_count
);

   localparam logic [31:0] HOLD_LAST = (RESET_HOLD > 0) ? 32'(RESET_HOLD - 1) : 32'd0;

   seq_state_t        state, state_nxt;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       hold_cnt;
   logic [31:0]       csr_s;
   logic              handshake;
   logic              addr_max;
   logic              overflow;
   logic              launch;
   logic              wd_expired;

`ifdef ISA_SEQ_CSR_SYNC_EN
   logic [31:0] csr_meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         csr_meta <= '0;
         csr_s    <= '0;
      end else begin
         csr_meta <= csr;
         csr_s    <= csr_meta;
      end
   end
`else
   assign csr_s = csr;
`endif

   assign ld.load_ready = (state == LOAD);
   assign handshake     = ld.load_valid & ld.load_ready;
   assign addr_max      = (addr == {ADDR_W{1'b1}});
   assign overflow      = handshake & ~ld.load_last & addr_max;
   assign launch        = start & ((state == IDLE) | (state == DONE));

   assign mem_we    = handshake;
   assign mem_addr  = addr;
   assign mem_wdata = ld.load_data;
   assign cpu_rst   = (state != RUN);
   assign busy      = (state == LOAD) | (state == HOLD) | (state == RUN);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = LOAD;
         LOAD: begin
            if (handshake && ld.load_last) state_nxt = HOLD;
            else if (overflow)             state_nxt = DONE;
         end
         HOLD: if (hold_cnt == HOLD_LAST) state_nxt = RUN;
         RUN:  if (csr_s[0] || wd_expired) state_nxt = DONE;
         DONE: if (start) state_nxt = LOAD;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         addr     <= '0;
         hold_cnt <= '0;
         done     <= 1'b0;
         pass     <= 1'b0;
         fail_id  <= '0;
         timeout  <= 1'b0;
         load_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= (state == HOLD) ? hold_cnt + 32'd1 : 32'd0;

         if (launch) begin
            addr     <= '0;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail_id  <= '0;
            timeout  <= 1'b0;
            load_err <= 1'b0;
         end else if (state == LOAD) begin
            // The address saturates: the overflowing word is written, then loading stops.
            if (handshake && !ld.load_last && !addr_max) addr <= addr + 1'b1;
            if (overflow) begin
               load_err <= 1'b1;
               done     <= 1'b1;
            end
         end else if (state == RUN) begin
            // A tohost write in the expiry cycle takes priority over the watchdog.
            if (csr_s[0]) begin
               done    <= 1'b1;
               pass    <= (csr_s == TOHOST_PASS);
               fail_id <= csr_s[31:1];
            end else if (wd_expired) begin
               done    <= 1'b1;
               timeout <= 1'b1;
            end
         end
      end
   end

   isa_seq_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk         (clk),
      .rst         (rst),
      .enable      ((state == RUN) && (state_nxt == RUN)),
      .clear       (launch),
      .cycle_count (cycle_count),
      .expired     (wd_expired)
   );

endmodule

// File: tb/tb_isa_test_sequencer.sv
// Directed bench for isa_test_sequencer: pass, fail code, watchdog, overflow,
// restart and reset; expected latencies track ISA_SEQ_CSR_SYNC_EN.
module tb_isa_test_sequencer;
   import isa_seq_pkg::*;

   localparam int ADDR_W         = 2;
   localparam int RESET_HOLD     = 30;
   localparam int TIMEOUT_CYCLES = 1000;
`ifdef ISA_SEQ_CSR_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [31:0]       csr = '0;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_rst, busy, done, pass, timeout, load_err;
   logic [30:0]       fail_id;
   logic [31:0]       cycle_count;

   isa_test_sequencer_if ld();

   isa_test_sequencer #(
      .ADDR_W         (ADDR_W),
      .RESET_HOLD     (RESET_HOLD),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .ld          (ld),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .cpu_rst     (cpu_rst),
      .csr         (csr),
      .busy        (busy),
      .done        (done),
      .pass        (pass),
      .fail_id     (fail_id),
      .timeout     (timeout),
      .load_err    (load_err),
      .cycle_count (cycle_count)
   );

   always #5 clk = ~clk;

   // Write and run-cycle monitor, sampled on the active edge.
   int                wr_cnt = 0;
   int                run_cnt = 0;
   logic [ADDR_W-1:0] last_wr_addr = '0;
   logic [31:0]       last_wr_data = '0;

   always @(posedge clk) begin
      if (mem_we) begin
         wr_cnt       = wr_cnt + 1;
         last_wr_addr = mem_addr;
         last_wr_data = mem_wdata;
      end
      if (!cpu_rst) run_cnt = run_cnt + 1;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic load_one(input logic [31:0] data);
      ld.load_valid = 1'b1;
      ld.load_data  = data;
      ld.load_last  = 1'b1;
      step();
      ld.load_valid = 1'b0;
      ld.load_last  = 1'b0;
   endtask

   task automatic wait_release(input int bound, output int n);
      n = 0;
      while (cpu_rst && n < bound) begin
         step();
         n++;
      end
   endtask

   task automatic wait_done(input int bound, output int n);
      n = 0;
      while (!done && n < bound) begin
         step();
         n++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout observed running expected finished");
      $fatal(1);
   end

   logic [31:0] img [4];
   int          n;
   int          wr_base;
   int          run_base;

   initial begin
      img[0] = 32'h0000_0093;
      img[1] = 32'h0010_0113;
      img[2] = 32'h0020_0193;
      img[3] = 32'h0000_006F;

      // Reset, with a valid word presented that must be ignored.
      ld.load_valid = 1'b1;
      ld.load_data  = 32'hDEAD_BEEF;
      ld.load_last  = 1'b0;
      step(3);
      check("rst_cpu_rst",     32'(cpu_rst), 32'd1);
      check("rst_load_ready",  32'(ld.load_ready), 32'd0);
      check("rst_mem_we",      32'(mem_we), 32'd0);
      check("rst_busy",        32'(busy), 32'd0);
      check("rst_done",        32'(done), 32'd0);
      check("rst_pass",        32'(pass), 32'd0);
      check("rst_timeout",     32'(timeout), 32'd0);
      check("rst_load_err",    32'(load_err), 32'd0);
      check("rst_fail_id",     32'(fail_id), 32'd0);
      check("rst_cycle_count", cycle_count, 32'd0);
      check("rst_mem_addr",    32'(mem_addr), 32'd0);
      rst = 1'b0;
      step(2);
      check("idle_mem_we",    32'(mem_we), 32'd0);
      check("idle_no_writes", 32'(wr_cnt), 32'd0);
      ld.load_valid = 1'b0;

      // Normal pass: 4-word image with one backpressure gap.
      pulse_start();
      check("load_ready_after_start", 32'(ld.load_ready), 32'd1);
      check("load_busy",              32'(busy), 32'd1);
      check("load_cpu_rst",           32'(cpu_rst), 32'd1);
      wr_base = wr_cnt;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) begin
            ld.load_valid = 1'b0;
            #1;
            check("bp_gap_mem_we", 32'(mem_we), 32'd0);
            step();
         end
         ld.load_valid = 1'b1;
         ld.load_data  = img[i];
         ld.load_last  = (i == 3);
         #1;
         check("load_mem_we",    32'(mem_we), 32'd1);
         check("load_mem_addr",  32'(mem_addr), 32'(i));
         check("load_mem_wdata", mem_wdata, img[i]);
         step();
      end
      ld.load_valid = 1'b0;
      ld.load_last  = 1'b0;
      check("hold_load_ready",  32'(ld.load_ready), 32'd0);
      check("hold_cpu_rst",     32'(cpu_rst), 32'd1);
      check("load_write_count", 32'(wr_cnt - wr_base), 32'd4);
      check("load_last_addr",   32'(last_wr_addr), 32'd3);
      check("load_last_data",   last_wr_data, img[3]);
      wait_release(100, n);
      check("hold_length",     32'(n), 32'(RESET_HOLD));
      check("run_first_count", cycle_count, 32'd0);
      step(10);
      check("run_count_10", cycle_count, 32'd10);
      pulse_start();
      check("run_start_ignored_cpu_rst", 32'(cpu_rst), 32'd0);
      check("run_start_ignored_ready",   32'(ld.load_ready), 32'd0);
      check("run_start_ignored_count",   cycle_count, 32'd11);
      step(39);
      check("run_count_50", cycle_count, 32'd50);
      csr = 32'h1;
      wait_done(20, n);
      check("pass_detect_latency", 32'(n), 32'(1 + SYNC_LAT));
      check("pass_done",    32'(done), 32'd1);
      check("pass_pass",    32'(pass), 32'd1);
      check("pass_cpu_rst", 32'(cpu_rst), 32'd1);
      check("pass_busy",    32'(busy), 32'd0);
      check("pass_timeout", 32'(timeout), 32'd0);
      check("pass_fail_id", 32'(fail_id), 32'd0);
      check("pass_count",   cycle_count, 32'(50 + SYNC_LAT));
      csr = 32'h0;
      step(3);
      check("done_level",   32'(done), 32'd1);
      check("count_frozen", cycle_count, 32'(50 + SYNC_LAT));

      // Restart from DONE clears results; single-word image; fail code 3.
      pulse_start();
      check("restart_done",      32'(done), 32'd0);
      check("restart_pass",      32'(pass), 32'd0);
      check("restart_count",     cycle_count, 32'd0);
      check("restart_mem_addr",  32'(mem_addr), 32'd0);
      check("restart_ready",     32'(ld.load_ready), 32'd1);
      wr_base = wr_cnt;
      load_one(32'h1234_5678);
      check("single_word_hold",   32'(ld.load_ready), 32'd0);
      check("single_word_writes", 32'(wr_cnt - wr_base), 32'd1);
      wait_release(100, n);
      check("single_hold_length", 32'(n), 32'(RESET_HOLD));
      step(5);
      csr = 32'h7;
      wait_done(20, n);
      check("fail_done",    32'(done), 32'd1);
      check("fail_pass",    32'(pass), 32'd0);
      check("fail_id",      32'(fail_id), 32'd3);
      check("fail_timeout", 32'(timeout), 32'd0);
      csr = 32'h0;

      // Watchdog expiry with csr held at zero.
      pulse_start();
      load_one(32'h0000_0013);
      wait_release(100, n);
      wait_done(TIMEOUT_CYCLES + 100, n);
      check("wd_cycles",  32'(n), 32'(TIMEOUT_CYCLES));
      check("wd_timeout", 32'(timeout), 32'd1);
      check("wd_pass",    32'(pass), 32'd0);
      check("wd_cpu_rst", 32'(cpu_rst), 32'd1);
      check("wd_count",   cycle_count, 32'(TIMEOUT_CYCLES - 1));

      // CSR pass landing in the expiry cycle wins over the watchdog.
      pulse_start();
      load_one(32'h0000_0013);
      wait_release(100, n);
      step(TIMEOUT_CYCLES - 1 - SYNC_LAT);
      check("tie_pre_count", cycle_count, 32'(TIMEOUT_CYCLES - 1 - SYNC_LAT));
      csr = 32'h1;
      wait_done(20, n);
      check("tie_latency", 32'(n), 32'(1 + SYNC_LAT));
      check("tie_pass",    32'(pass), 32'd1);
      check("tie_timeout", 32'(timeout), 32'd0);
      check("tie_count",   cycle_count, 32'(TIMEOUT_CYCLES - 1));
      csr = 32'h0;

      // Overflow: 5 words, no load_last, valid toggling every other cycle.
      pulse_start();
      wr_base  = wr_cnt;
      run_base = run_cnt;
      for (int i = 0; i < 5; i++) begin
         ld.load_valid = 1'b1;
         ld.load_data  = 32'hA000_0000 + 32'(i);
         ld.load_last  = 1'b0;
         #1;
         check("ovf_mem_we", 32'(mem_we), (i < 4) ? 32'd1 : 32'd0);
         step();
         ld.load_valid = 1'b0;
         step();
      end
      step(5);
      check("ovf_writes",   32'(wr_cnt - wr_base), 32'd4);
      check("ovf_last_addr", 32'(last_wr_addr), 32'd3);
      check("ovf_load_err", 32'(load_err), 32'd1);
      check("ovf_done",     32'(done), 32'd1);
      check("ovf_pass",     32'(pass), 32'd0);
      check("ovf_busy",     32'(busy), 32'd0);
      check("ovf_no_run",   32'(run_cnt - run_base), 32'd0);

      // Reset in the middle of a load.
      pulse_start();
      check("reload_load_err", 32'(load_err), 32'd0);
      ld.load_valid = 1'b1;
      ld.load_data  = 32'h5555_AAAA;
      step(2);
      check("midload_addr", 32'(mem_addr), 32'd2);
      rst = 1'b1;
      step();
      check("midrst_cpu_rst",    32'(cpu_rst), 32'd1);
      check("midrst_load_ready", 32'(ld.load_ready), 32'd0);
      check("midrst_busy",       32'(busy), 32'd0);
      check("midrst_mem_addr",   32'(mem_addr), 32'd0);
      rst = 1'b0;
      wr_base = wr_cnt;
      step(3);
      check("idle_valid_ignored", 32'(wr_cnt - wr_base), 32'd0);
      ld.load_valid = 1'b0;
      pulse_start();
      check("post_rst_ready", 32'(ld.load_ready), 32'd1);
      check("post_rst_addr",  32'(mem_addr), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/isa_test_sequencer.md
# isa_test_sequencer

Hardware sequencer that runs one RV32I ISA test on the CPU system without simulator-only hooks. It streams a program image into the shared IMEM/DMEM write port while holding the CPU in reset, then releases the CPU after a fixed hold. It watches the tohost CSR for completion, enforces a cycle watchdog, and latches pass/fail/timeout status for LEDs, HEX displays or a bench. It sits between the image source (UART loader or bench driver) and `SMU_RV32I_System`, and owns the CPU reset.

## Interface
- `ADDR_W`, 14: word-address width of the image/memory write port
- `RESET_HOLD`, 30: cycles `cpu_rst` stays high after the last image word
- `TIMEOUT_CYCLES`, 1000: RUN-state cycle budget; 0 disables the watchdog
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  single-cycle pulse; begins a load/run sequence
- `load_valid`  in  1  image word valid
- `load_ready`  out  1  sequencer accepts the word
- `load_data`  in  32  image word
- `load_last`  in  1  marks the final image word
- `mem_we`  out  1  write strobe to both IMEM and DMEM
- `mem_addr`  out  ADDR_W  word address
- `mem_wdata`  out  32  write data
- `cpu_rst`  out  1  active-high CPU reset
- `csr`  in  32  tohost CSR value
- `busy`  out  1  state is LOAD, HOLD or RUN
- `done`  out  1  sticky result-valid flag
- `pass`  out  1  result: `csr[0]==1` and `csr[31:1]==0`
- `fail_id`  out  31  latched `csr[31:1]`
- `timeout`  out  1  watchdog expired
- `load_err`  out  1  image overflowed the address space
- `cycle_count`  out  32  RUN cycles elapsed; frozen in DONE

## Operation
- States:
  - IDLE: `cpu_rst`=1. `start` moves to LOAD.
  - LOAD: `cpu_rst`=1, `load_ready`=1, address counter starts at 0. Each handshake writes one word and increments the address. A handshake with `load_last` moves to HOLD.
  - HOLD: `cpu_rst`=1 for `RESET_HOLD` cycles, then RUN.
  - RUN: `cpu_rst`=0, `cycle_count` increments each cycle. Either exit condition moves to DONE (see Completion).
  - DONE: `cpu_rst`=1, results held. `start` moves to LOAD and clears `done`, `pass`, `fail_id`, `timeout`, `load_err` and `cycle_count`.
- Write port: `mem_we` = `load_valid & load_ready`. `mem_addr` = address register. `mem_wdata` = `load_data`. All three are same-cycle, so a word is written on the cycle it is accepted.
- Completion:
  - `csr[0]==1` sampled in RUN: latch `pass` and `fail_id`.
  - `cycle_count == TIMEOUT_CYCLES-1` (when `TIMEOUT_CYCLES`≠0): set `timeout`.
  - If both occur in the same cycle, the CSR result wins and `timeout`=0.
- Overflow: a handshake at address 2^ADDR_W−1 without `load_last` sets `load_err` and goes to DONE with `pass`=0. The address never wraps.
- `start` is ignored in LOAD, HOLD and RUN.
- `load_valid` outside LOAD is ignored; no write occurs.
- A single-word image (`load_last` on the first handshake) is legal.
- `rst` during any state: return to IDLE next edge. Any in-flight load is abandoned.

## Timing
- Reset values: `cpu_rst`=1. `load_ready`, `mem_we`, `busy`, `done`, `pass`, `timeout`, `load_err`=0. `fail_id`, `cycle_count`, `mem_addr`=0.
- Transitions:
  - `start` at edge N: `load_ready`=1 from N+1.
  - Last handshake at edge N: HOLD from N+1, `cpu_rst` falls at N+1+`RESET_HOLD`.
  - `cycle_count` is 0 on the first RUN cycle.
- Detection: `csr[0]` sampled high at edge N gives `done`=1 and `cpu_rst`=1 at N+1. With the synchronizer enabled, detection moves 2 cycles later.
- `done` is level, not pulse; it is held until the next `start` or `rst`.

## Configuration
- `ISA_SEQ_CSR_SYNC_EN` defined: `csr` passes through a two-flop synchronizer before the completion check. This adds 2 cycles of detection latency, and `cycle_count` includes them.
- Undefined: `csr` is sampled directly; single-clock system only.

## Structure
- Package `isa_seq_pkg`:
  - state enum (IDLE, LOAD, HOLD, RUN, DONE)
  - `TOHOST_PASS` constant (32'h1)
  - status-bit positions for an LED vector {`load_err`, `timeout`, `pass`, `done`}
- Sub-module `isa_seq_watchdog`:
  - inputs: enable, clear
  - outputs: `cycle_count` and the expire flag
  - owns the `TIMEOUT_CYCLES`=0 bypass
- FSM, address counter and result latches stay in the top module.

## Test plan
- **Normal pass:** `RESET_HOLD`=30, 4-word image; `csr` goes 32'h1 at RUN cycle 50 → 4 writes at addresses 0–3, `cpu_rst` low 30 cycles after the last word, `done`=1, `pass`=1, `cycle_count`=50.
- **Fail code:** `csr`=32'h7 (test 3 fails) → `done`=1, `pass`=0, `fail_id`=3, `timeout`=0.
- **Watchdog:** `TIMEOUT_CYCLES`=1000, `csr` stays 0 → `timeout`=1 after exactly 1000 RUN cycles, `cpu_rst`=1. With `csr[0]` rising on cycle 999 → `pass`=1, `timeout`=0.
- **Backpressure/overflow:** `ADDR_W`=2, `load_valid` toggling every other cycle, 5 words without `load_last` → 4 writes only, `load_err`=1, no RUN.
- **Restart and reset:** `start` during RUN → ignored. `start` in DONE → results cleared, new load from address 0. `rst` mid-LOAD → IDLE, `cpu_rst`=1, `load_ready`=0.
- **Sync macro:** rerun the normal-pass case with `ISA_SEQ_CSR_SYNC_EN` → `done` 2 cycles later, `cycle_count`=52.
